// File: rtl/decode_dispatch_queue_pkg.sv
// Shared types for the decode/dispatch queue: instruction classes, reservation
// stations, immediate-source encodings and the decoded control word.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_R     = 4'b0001,
    OP_I     = 4'b0010,
    OP_S     = 4'b0011,
    OP_B     = 4'b0100,
    OP_LUI   = 4'b0101,
    OP_JAL   = 4'b0110,
    OP_AUIPC = 4'b0111,
    OP_JALR  = 4'b1000,
    OP_LOAD  = 4'b1001,
    OP_MUL   = 4'b1010
  } opcode_e;

  typedef enum logic [1:0] {
    ST_ALU    = 2'd0,
    ST_BRANCH = 2'd1,
    ST_LSU    = 2'd2,
    ST_MUL    = 2'd3
  } station_e;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef struct packed {
    logic [2:0] immSrc;
    logic [1:0] aluOp;
    station_e   station;
    logic       memWrite;
    logic       memRead;
    logic       isJAL;
    logic       isJALR;
    logic       isLUI;
    logic       isAUIPC;
    logic       useImm;
    logic       regWrite;
    logic       stationRequest;
    logic       robWrite;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_dispatch_queue_ctrl_decode.sv
// Combinational instruction-class decoder: opcode and destination register
// to a packed control word.
module ctrl_decode
  import decode_pkg::*;
(
  input  logic [3:0]        i_opcode,
  input  logic [4:0]        i_dest_reg,
  output logic [CTRL_W-1:0] o_ctrl
);

  ctrl_t w_c;

  always_comb begin
    w_c                = '0;
    w_c.aluOp          = 2'b11;
    w_c.immSrc         = IMM_I;
    w_c.station        = ST_ALU;
    w_c.useImm         = 1'b1;
    w_c.robWrite       = 1'b1;
    w_c.stationRequest = 1'b1;
    w_c.regWrite       = (i_dest_reg != 5'd0);
    case (i_opcode)
      OP_R:     begin w_c.aluOp = 2'b00; w_c.immSrc = IMM_NONE; w_c.useImm = 1'b0; end
      OP_I:     w_c.aluOp = 2'b00;
      OP_S:     begin
        w_c.aluOp = 2'b10; w_c.immSrc = IMM_S; w_c.memWrite = 1'b1;
        w_c.regWrite = 1'b0; w_c.station = ST_LSU;
      end
      OP_B:     begin
        w_c.aluOp = 2'b01; w_c.immSrc = IMM_B; w_c.useImm = 1'b0;
        w_c.regWrite = 1'b0; w_c.station = ST_BRANCH;
      end
      OP_LUI:   begin w_c.immSrc = IMM_U; w_c.isLUI = 1'b1; end
      // JAL resolves at rename; it only needs a ROB slot
      OP_JAL:   begin w_c.immSrc = IMM_J; w_c.isJAL = 1'b1; w_c.stationRequest = 1'b0; end
      OP_AUIPC: begin w_c.immSrc = IMM_U; w_c.isAUIPC = 1'b1; end
      OP_JALR:  begin w_c.isJALR = 1'b1; w_c.station = ST_BRANCH; end
      OP_LOAD:  begin w_c.aluOp = 2'b10; w_c.memRead = 1'b1; w_c.station = ST_LSU; end
      OP_MUL:   begin w_c.aluOp = 2'b00; w_c.useImm = 1'b0; w_c.station = ST_MUL; end
      default:  begin
        w_c.illegal = 1'b1; w_c.stationRequest = 1'b0;
        w_c.robWrite = 1'b0; w_c.regWrite = 1'b0;
      end
    endcase
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/decode_dispatch_queue.sv
// Multi-slot decode into an in-order FIFO; issues the oldest entry when its
// reservation station and the ROB can take it, dropping illegal entries.
module decode_dispatch_queue
  import decode_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [WIDTH-1:0]              i_in_valid,
  input  logic [WIDTH*4-1:0]            i_in_opcode,
  input  logic [WIDTH*5-1:0]            i_in_dest_reg,
  input  logic [WIDTH*PAYLOAD_W-1:0]    i_in_payload,
  output logic                          o_in_ready,
  input  logic                          i_flush,
  input  logic [3:0]                    i_rs_ready,
  input  logic                          i_rob_ready,
  output logic                          o_disp_valid,
  output logic [CTRL_W-1:0]             o_disp_ctrl,
  output logic [PAYLOAD_W-1:0]          o_disp_payload,
  output logic                          o_illegal,
  output logic [$clog2(DEPTH+1)-1:0]    o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CTRL_W-1:0]    w_dec [WIDTH];
  logic [CTRL_W-1:0]    r_mem_ctrl [DEPTH];
  logic [PAYLOAD_W-1:0] r_mem_pay [DEPTH];
  logic [DEPTH-1:0]     r_ent_valid;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [CNT_W-1:0]     w_push_cnt;
  logic                 w_in_ready, w_push, w_head_valid;
  logic                 w_rs_ok, w_rob_ok, w_drop, w_fire, w_pop;
  ctrl_t                w_head;

  for (genvar g = 0; g < WIDTH; g++) begin : g_dec
    ctrl_decode u_ctrl_decode (
      .i_opcode   (i_in_opcode[g*4 +: 4]),
      .i_dest_reg (i_in_dest_reg[g*5 +: 5]),
      .o_ctrl     (w_dec[g])
    );
  end

  // Readiness looks only at the registered count; a same-cycle pop is not credited
  assign w_in_ready = ({1'b0, r_count} + (CNT_W+1)'(WIDTH)) <= (CNT_W+1)'(DEPTH);
  assign w_push     = i_in_valid[0] && w_in_ready && !i_flush;

  always_comb begin
    w_push_cnt = '0;
    for (int s = 0; s < WIDTH; s++) w_push_cnt = w_push_cnt + CNT_W'(i_in_valid[s]);
  end

  assign w_head       = ctrl_t'(r_mem_ctrl[r_head]);
  assign w_head_valid = (r_count != '0) && r_ent_valid[r_head];
  assign w_rs_ok      = !w_head.stationRequest || i_rs_ready[w_head.station];
  assign w_rob_ok     = !w_head.robWrite || i_rob_ready;
  assign w_drop       = w_head_valid && w_head.illegal && !i_flush;
  assign w_fire       = w_head_valid && !w_head.illegal && w_rs_ok && w_rob_ok && !i_flush;
  assign w_pop        = w_drop || w_fire;

  always_ff @(posedge i_clk) begin
    for (int s = 0; s < WIDTH; s++) begin
      if (w_push && i_in_valid[s]) begin
        r_mem_ctrl[r_tail + PTR_W'(s)] <= w_dec[s];
        r_mem_pay[r_tail + PTR_W'(s)]  <= i_in_payload[s*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ent_valid <= '0;
    end else if (i_flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ent_valid <= '0;
    end else begin
      if (w_pop) begin
        r_head              <= r_head + PTR_W'(1);
        r_ent_valid[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(w_push_cnt);
        for (int s = 0; s < WIDTH; s++)
          if (i_in_valid[s]) r_ent_valid[r_tail + PTR_W'(s)] <= 1'b1;
      end
      r_count <= r_count + (w_push ? w_push_cnt : CNT_W'(0)) - CNT_W'(w_pop);
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_disp_valid   = w_fire;
  assign o_illegal      = w_drop;
  assign o_disp_ctrl    = r_mem_ctrl[r_head];
  assign o_disp_payload = r_mem_pay[r_head];
  assign o_count        = r_count;

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed bench for decode_dispatch_queue: decode fields, stalls, drops,
// back-to-back push/pop, fill, flush and asynchronous reset.
module tb_decode_dispatch_queue;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  in_valid = '0;
  logic [7:0]  in_opcode = '0;
  logic [9:0]  in_dest = '0;
  logic [63:0] in_payload = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [3:0]  rs_ready = 4'hF;
  logic        rob_ready = 1'b1;
  logic        disp_valid;
  logic [CTRL_W-1:0] disp_ctrl;
  logic [31:0] disp_payload;
  logic        illegal;
  logic [3:0]  count;
  ctrl_t       dc;

  int checks = 0;
  int failures = 0;

  assign dc = ctrl_t'(disp_ctrl);

  always #5 clk = ~clk;

  decode_dispatch_queue #(.WIDTH(2), .DEPTH(8), .PAYLOAD_W(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_in_opcode(in_opcode),
    .i_in_dest_reg(in_dest), .i_in_payload(in_payload), .o_in_ready(in_ready),
    .i_flush(flush), .i_rs_ready(rs_ready), .i_rob_ready(rob_ready),
    .o_disp_valid(disp_valid), .o_disp_ctrl(disp_ctrl), .o_disp_payload(disp_payload),
    .o_illegal(illegal), .o_count(count)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] o0, input logic [4:0] d0,
                       input logic [31:0] p0, input logic [3:0] o1, input logic [4:0] d1,
                       input logic [31:0] p1);
    in_valid   = v;
    in_opcode  = {o1, o0};
    in_dest    = {d1, d0};
    in_payload = {p1, p0};
  endtask

  task automatic idle();
    in_valid = 2'b00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (disp_valid !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_outs got=%b%b exp=00", disp_valid, illegal); end
    adv();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL post_reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_r_then_b();
    adv();
    rs_ready = 4'hF; rob_ready = 1'b1;
    drive(2'b11, OP_R, 5'd3, 32'hA0, OP_B, 5'd5, 32'hB0);
    @(negedge clk);
    checks++; if (disp_valid !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL empty_no_disp got=%b%b exp=00", disp_valid, illegal); end
    adv(); idle();
    @(negedge clk);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL rb_count0 got=%0d exp=2", count); end
    checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL r_disp_valid got=%b exp=1", disp_valid); end
    checks++; if (dc.aluOp !== 2'b00 || dc.useImm !== 1'b0 || dc.immSrc !== 3'b111) begin failures++; $display("FAIL r_fields got=alu%b imm%b src%b exp=alu00 imm0 src111", dc.aluOp, dc.useImm, dc.immSrc); end
    checks++; if (dc.regWrite !== 1'b1 || dc.station !== ST_ALU) begin failures++; $display("FAIL r_rw_station got=%b/%0d exp=1/0", dc.regWrite, dc.station); end
    checks++; if (disp_payload !== 32'hA0) begin failures++; $display("FAIL r_payload got=%h exp=a0", disp_payload); end
    adv();
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || count !== 4'd1) begin failures++; $display("FAIL b_disp got=%b cnt=%0d exp=1 cnt=1", disp_valid, count); end
    checks++; if (dc.regWrite !== 1'b0 || dc.station !== ST_BRANCH || dc.aluOp !== 2'b01) begin failures++; $display("FAIL b_fields got=rw%b st%0d alu%b exp=rw0 st1 alu01", dc.regWrite, dc.station, dc.aluOp); end
    checks++; if (disp_payload !== 32'hB0) begin failures++; $display("FAIL b_payload got=%h exp=b0", disp_payload); end
    adv();
    @(negedge clk);
    checks++; if (count !== 4'd0 || disp_valid !== 1'b0) begin failures++; $display("FAIL rb_drained got=cnt%0d v%b exp=cnt0 v0", count, disp_valid); end
  endtask

  task automatic test_i_dest0();
    adv();
    drive(2'b01, OP_I, 5'd0, 32'hC0, OP_R, 5'd0, 32'h0);
    adv(); idle();
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL i_disp_valid got=%b exp=1", disp_valid); end
    checks++; if (dc.regWrite !== 1'b0 || dc.useImm !== 1'b1 || dc.immSrc !== 3'b000 || dc.aluOp !== 2'b00) begin failures++; $display("FAIL i_fields got=rw%b imm%b src%b alu%b exp=rw0 imm1 src000 alu00", dc.regWrite, dc.useImm, dc.immSrc, dc.aluOp); end
    adv();
  endtask

  task automatic test_load_stall();
    adv();
    rs_ready = 4'b1011;
    drive(2'b01, OP_LOAD, 5'd7, 32'hD7, OP_R, 5'd0, 32'h0);
    adv(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (disp_valid !== 1'b0 || count !== 4'd1) begin failures++; $display("FAIL load_stall%0d got=v%b cnt%0d exp=v0 cnt1", i, disp_valid, count); end
      adv();
    end
    rs_ready = 4'hF;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || dc.memRead !== 1'b1 || dc.station !== ST_LSU || dc.aluOp !== 2'b10) begin failures++; $display("FAIL load_fire got=v%b mr%b st%0d alu%b exp=v1 mr1 st2 alu10", disp_valid, dc.memRead, dc.station, dc.aluOp); end
    adv();
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL load_drained got=%0d exp=0", count); end
  endtask

  task automatic test_jal();
    adv();
    rs_ready = 4'h0; rob_ready = 1'b0;
    drive(2'b01, OP_JAL, 5'd1, 32'hE5, OP_R, 5'd0, 32'h0);
    adv(); idle();
    @(negedge clk);
    checks++; if (disp_valid !== 1'b0 || count !== 4'd1) begin failures++; $display("FAIL jal_rob_stall got=v%b cnt%0d exp=v0 cnt1", disp_valid, count); end
    adv();
    rob_ready = 1'b1;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || dc.isJAL !== 1'b1 || dc.stationRequest !== 1'b0 || dc.immSrc !== 3'b100) begin failures++; $display("FAIL jal_fire got=v%b jal%b sr%b src%b exp=v1 jal1 sr0 src100", disp_valid, dc.isJAL, dc.stationRequest, dc.immSrc); end
    adv();
    rs_ready = 4'hF;
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL jal_drained got=%0d exp=0", count); end
  endtask

  task automatic test_illegal();
    adv();
    drive(2'b11, 4'hF, 5'd4, 32'hE0, OP_R, 5'd2, 32'hE1);
    adv(); idle();
    @(negedge clk);
    checks++; if (illegal !== 1'b1 || disp_valid !== 1'b0 || count !== 4'd2) begin failures++; $display("FAIL illegal_drop got=il%b v%b cnt%0d exp=il1 v0 cnt2", illegal, disp_valid, count); end
    adv();
    @(negedge clk);
    checks++; if (illegal !== 1'b0 || disp_valid !== 1'b1 || count !== 4'd1 || disp_payload !== 32'hE1) begin failures++; $display("FAIL after_illegal got=il%b v%b cnt%0d p%h exp=il0 v1 cnt1 pe1", illegal, disp_valid, count, disp_payload); end
    adv();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pay [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
    logic [3:0]  exp_cnt [6] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1};
    adv();
    drive(2'b11, OP_I, 5'd1, 32'h10, OP_MUL, 5'd2, 32'h11);
    for (int k = 0; k < 6; k++) begin
      adv();
      if (k == 0) drive(2'b11, OP_I, 5'd1, 32'h12, OP_MUL, 5'd2, 32'h13);
      else if (k == 1) drive(2'b11, OP_I, 5'd1, 32'h14, OP_MUL, 5'd2, 32'h15);
      else idle();
      @(negedge clk);
      checks++; if (disp_valid !== 1'b1 || disp_payload !== exp_pay[k] || count !== exp_cnt[k]) begin failures++; $display("FAIL b2b_%0d got=v%b p%h cnt%0d exp=v1 p%h cnt%0d", k, disp_valid, disp_payload, count, exp_pay[k], exp_cnt[k]); end
    end
    adv();
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", count); end
  endtask

  task automatic test_fill_flush();
    adv();
    rs_ready = 4'h0;
    drive(2'b11, OP_R, 5'd1, 32'hF0, OP_R, 5'd2, 32'hF1);
    adv(); adv(); adv();
    drive(2'b01, OP_R, 5'd3, 32'hF6, OP_R, 5'd0, 32'h0);
    adv();
    drive(2'b11, OP_R, 5'd1, 32'hF8, OP_R, 5'd2, 32'hF9);
    @(negedge clk);
    checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin failures++; $display("FAIL fill7 got=cnt%0d rdy%b exp=cnt7 rdy0", count, in_ready); end
    adv();
    @(negedge clk);
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL full_reject got=%0d exp=7", count); end
    adv();
    flush = 1'b1; rs_ready = 4'hF;
    @(negedge clk);
    checks++; if (disp_valid !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL flush_no_disp got=v%b il%b exp=v0 il0", disp_valid, illegal); end
    adv();
    flush = 1'b0; idle();
    @(negedge clk);
    checks++; if (count !== 4'd0 || in_ready !== 1'b1 || disp_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=cnt%0d rdy%b v%b exp=cnt0 rdy1 v0", count, in_ready, disp_valid); end
    adv();
    drive(2'b01, OP_R, 5'd9, 32'hD0, OP_R, 5'd0, 32'h0);
    adv(); idle();
    @(negedge clk);
    checks++; if (disp_valid !== 1'b1 || disp_payload !== 32'hD0 || count !== 4'd1) begin failures++; $display("FAIL post_flush got=v%b p%h cnt%0d exp=v1 pd0 cnt1", disp_valid, disp_payload, count); end
    adv();
  endtask

  task automatic test_reset_mid();
    adv();
    rs_ready = 4'h0;
    drive(2'b11, OP_S, 5'd1, 32'h51, OP_R, 5'd2, 32'h52);
    adv(); idle();
    @(negedge clk);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL pre_reset_count got=%0d exp=2", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || in_ready !== 1'b1 || disp_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=cnt%0d rdy%b v%b exp=cnt0 rdy1 v0", count, in_ready, disp_valid); end
    adv();
    reset = 1'b0; rs_ready = 4'hF;
    @(negedge clk);
    checks++; if (count !== 4'd0 || disp_valid !== 1'b0) begin failures++; $display("FAIL after_reset got=cnt%0d v%b exp=cnt0 v0", count, disp_valid); end
  endtask

  initial begin
    test_reset();
    test_r_then_b();
    test_i_dest0();
    test_load_stall();
    test_jal();
    test_illegal();
    test_back_to_back();
    test_fill_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
